// File: rtl/piece_collision_check_if.sv
// Request/result, shape-ROM and playfield-row signals of the piece collision checker.
`timescale 1ns/1ps
interface piece_collision_check_if #(
  parameter int BOARD_W = 10
);
  logic                 start;
  logic [2:0]           tetro_in;
  logic [1:0]           dir_in;
  logic signed [4:0]    pos_x;
  logic signed [5:0]    pos_y;
  logic [2:0]           rom_tetro;
  logic [1:0]           rom_dir;
  logic [3:0][3:0]      rom_data;
  logic [4:0]           board_row_addr;
  logic [BOARD_W-1:0]   board_row_data;
  logic                 busy;
  logic                 done;
  logic                 hit;

  modport master (
    output start, tetro_in, dir_in, pos_x, pos_y, rom_data, board_row_data,
    input  rom_tetro, rom_dir, board_row_addr, busy, done, hit
  );

  modport slave (
    input  start, tetro_in, dir_in, pos_x, pos_y, rom_data, board_row_data,
    output rom_tetro, rom_dir, board_row_addr, busy, done, hit
  );
endinterface

// File: rtl/piece_collision_check.sv
// Checks a 4x4 piece box against side walls, floor and playfield occupancy,
// one box row per cycle with a one-cycle board read pipeline.
`timescale 1ns/1ps
module piece_collision_check #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  piece_collision_check_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [6:0] BOARD_W_S = 7'(BOARD_W);
  localparam logic signed [6:0] BOARD_H_S = 7'(BOARD_H);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [1:0]          r_r;
  logic [2:0]          tetro_r;
  logic [1:0]          dir_r;
  logic signed [4:0]   pos_x_r;
  logic signed [5:0]   pos_y_r;
  logic [BOARD_W-1:0]  row_q_r;
  logic                row_valid_r;
  logic                hit_r;
  logic                busy_r;
  logic                done_r;
  logic [4:0]          addr_r;

  logic                accept_s;
  logic [3:0]          rom_row_s;
  logic signed [6:0]   pos_x_ext_s;
  logic signed [6:0]   row_y_s;
  logic signed [6:0]   row_y_next_s;
  logic                row_in_board_s;
  logic                wall_s;
  logic                floor_s;
  logic                occ_s;
  logic [BOARD_W-1:0]  shifted_s;
  logic signed [6:0]   col_v;
  logic signed [6:0]   diff_v;

  // Rows outside the playfield read address 0; their data is masked off anyway
  function automatic logic [4:0] row_addr(input logic signed [6:0] y);
    if (!y[6] && (y < BOARD_H_S)) begin
      row_addr = y[4:0];
    end else begin
      row_addr = 5'd0;
    end
  endfunction

  assign accept_s     = bus.start && ((state_r == IDLE) || (state_r == DONE));
  assign rom_row_s    = bus.rom_data[r_r];
  assign pos_x_ext_s  = {{2{pos_x_r[4]}}, pos_x_r};
  assign row_y_s      = {pos_y_r[5], pos_y_r} + {5'd0, r_r};
  assign row_y_next_s = row_y_s + 7'sd1;

  // Per-row wall/floor checks and alignment of the box row onto board columns
  always_comb begin
    wall_s         = 1'b0;
    shifted_s      = {BOARD_W{1'b0}};
    col_v          = 7'sd0;
    diff_v         = 7'sd0;
    row_in_board_s = !row_y_s[6] && (row_y_s < BOARD_H_S);
    floor_s        = (|rom_row_s) && !row_y_s[6] && (row_y_s >= BOARD_H_S);
    for (int c = 0; c < 4; c++) begin
      col_v  = pos_x_ext_s + 7'(c);
      wall_s = wall_s | (rom_row_s[3-c] & (col_v[6] | (col_v >= BOARD_W_S)));
    end
    for (int x = 0; x < BOARD_W; x++) begin
      diff_v = 7'(x) - pos_x_ext_s;
      if (!diff_v[6] && (diff_v < 7'sd4)) begin
        shifted_s[x] = rom_row_s[~diff_v[1:0]] & row_in_board_s;
      end else begin
        shifted_s[x] = 1'b0;
      end
    end
  end

  assign occ_s = row_valid_r && (|(row_q_r & bus.board_row_data));

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? SCAN : IDLE;
      SCAN:    state_nxt_s = (r_r == 2'd3) ? DRAIN : SCAN;
      DRAIN:   state_nxt_s = DONE;
      DONE:    state_nxt_s = accept_s ? SCAN : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, latched request, scan pipeline and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      r_r         <= 2'd0;
      tetro_r     <= 3'd0;
      dir_r       <= 2'd0;
      pos_x_r     <= 5'sd0;
      pos_y_r     <= 6'sd0;
      row_q_r     <= {BOARD_W{1'b0}};
      row_valid_r <= 1'b0;
      hit_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      addr_r      <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == SCAN) || (state_nxt_s == DRAIN);
      done_r  <= (state_nxt_s == DONE);
      if (accept_s) begin
        tetro_r     <= bus.tetro_in;
        dir_r       <= bus.dir_in;
        pos_x_r     <= bus.pos_x;
        pos_y_r     <= bus.pos_y;
        r_r         <= 2'd0;
        hit_r       <= 1'b0;
        row_q_r     <= {BOARD_W{1'b0}};
        row_valid_r <= 1'b0;
        addr_r      <= row_addr({bus.pos_y[5], bus.pos_y});
      end else if (state_r == SCAN) begin
        r_r         <= r_r + 2'd1;
        hit_r       <= hit_r | wall_s | floor_s | occ_s;
        row_q_r     <= shifted_s;
        row_valid_r <= row_in_board_s;
        addr_r      <= (r_r == 2'd3) ? 5'd0 : row_addr(row_y_next_s);
      end else if (state_r == DRAIN) begin
        hit_r       <= hit_r | occ_s;
        row_valid_r <= 1'b0;
      end else begin
        hit_r       <= hit_r;
      end
    end
  end

  assign bus.rom_tetro      = tetro_r;
  assign bus.rom_dir        = dir_r;
  assign bus.board_row_addr = addr_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.hit            = hit_r;
endmodule

// File: tb/tb_piece_collision_check.sv
// Directed bench for piece_collision_check with a small shape ROM and a
// registered playfield memory model.
`timescale 1ns/1ps
module tb_piece_collision_check;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   done_seen;
  logic [9:0] board [0:31];

  piece_collision_check_if #(.BOARD_W(10)) bus();

  piece_collision_check #(.BOARD_W(10), .BOARD_H(20)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written shapes; row 0 is the top box row, bit 3 the leftmost column
  function automatic logic [3:0][3:0] shape(input logic [2:0] t, input logic [1:0] d);
    logic [3:0][3:0] s;
    s = 16'h0000;
    case (t)
      3'd1: begin s[1] = 4'b0110; s[2] = 4'b0110; end
      3'd2: begin
        if (d[0] == 1'b0) begin
          s[0] = 4'b0100; s[1] = 4'b0100; s[2] = 4'b0100; s[3] = 4'b0100;
        end else begin
          s[1] = 4'b1111;
        end
      end
      3'd3: begin s[0] = 4'b0100; s[1] = 4'b1110; end
      3'd4: begin s[0] = 4'b0010; s[1] = 4'b1110; end
      3'd5: begin s[0] = 4'b1000; s[1] = 4'b1110; end
      3'd6: begin s[0] = 4'b1100; s[1] = 4'b0110; end
      3'd7: begin s[0] = 4'b0110; s[1] = 4'b1100; end
      default: s = 16'h0000;
    endcase
    return s;
  endfunction

  assign bus.rom_data = shape(bus.rom_tetro, bus.rom_dir);

  // Playfield memory: data appears one clock after the address is sampled
  always @(posedge clk) bus.board_row_data <= board[bus.board_row_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge inside the DONE cycle
  task automatic do_scan(input logic [2:0] t, input logic [1:0] d, input int px, input int py,
                         input logic exp_hit, input string tag, input int glitch_at);
    logic [4:0] addrs [0:3];
    int lat;
    int y;
    bus.start = 1'b1; bus.tetro_in = t; bus.dir_in = d;
    bus.pos_x = 5'(px); bus.pos_y = 6'(py);
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.tetro_in = 3'd0; bus.dir_in = 2'd0; bus.pos_x = 5'd0; bus.pos_y = 6'd0;
    @(negedge clk);
    addrs[0] = bus.board_row_addr;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (lat < 20) begin
      if (lat == glitch_at) begin
        bus.start = 1'b1; bus.tetro_in = 3'd1; bus.dir_in = 2'd0; bus.pos_x = 5'd0; bus.pos_y = 6'd0;
      end
      @(posedge clk);
      lat++;
      #1 bus.start = 1'b0;
      @(negedge clk);
      if (lat <= 3) addrs[lat] = bus.board_row_addr;
      if (bus.done) break;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_hit"}, 32'(bus.hit), 32'(exp_hit));
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rom_tetro"}, 32'(bus.rom_tetro), 32'(t));
    for (int k = 0; k < 4; k++) begin
      y = py + k;
      chk($sformatf("%s_addr%0d", tag, k), 32'(addrs[k]),
          ((y >= 0) && (y < 20)) ? 32'(y) : 32'd0);
    end
  endtask

  initial begin
    errors = 0; checks = 0; done_seen = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.tetro_in = 3'd0; bus.dir_in = 2'd0; bus.pos_x = 5'd0; bus.pos_y = 6'd0;
    for (int i = 0; i < 32; i++) board[i] = 10'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_hit", 32'(bus.hit), 32'd0);
    chk("reset_addr", 32'(bus.board_row_addr), 32'd0);
    chk("reset_tetro", 32'(bus.rom_tetro), 32'd0);
    chk("reset_dir", 32'(bus.rom_dir), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_scan(3'd1, 2'd0, 0, 0, 1'b0, "o_origin", -1);
    @(negedge clk); do_scan(3'd2, 2'd0, -1, 0, 1'b0, "i_left_ok", -1);
    @(negedge clk); do_scan(3'd2, 2'd0, -2, 0, 1'b1, "i_left_wall", -1);
    @(negedge clk); do_scan(3'd2, 2'd1, 6, 0, 1'b0, "i_right_ok", -1);
    @(negedge clk); do_scan(3'd2, 2'd1, 7, 0, 1'b1, "i_right_wall", -1);
    @(negedge clk); do_scan(3'd1, 2'd0, 0, 17, 1'b0, "o_floor_ok", -1);
    @(negedge clk); do_scan(3'd1, 2'd0, 0, 18, 1'b1, "o_floor_hit", -1);
    @(negedge clk); do_scan(3'd1, 2'd0, 0, 31, 1'b1, "o_far_below", -1);
    @(negedge clk); do_scan(3'd1, 2'd0, 0, -2, 1'b0, "o_above", -1);
    @(negedge clk); do_scan(3'd2, 2'd0, -2, -3, 1'b1, "i_wall_above", -1);
    @(negedge clk); do_scan(3'd0, 2'd0, -10, 18, 1'b0, "empty_piece", -1);

    board[5] = 10'b0000001000;
    @(negedge clk); do_scan(3'd3, 2'd0, 2, 4, 1'b1, "t_occupied", -1);
    // hit must hold after DONE until the next acceptance
    repeat (3) @(negedge clk);
    chk("hold_hit", 32'(bus.hit), 32'd1);
    chk("hold_done", 32'(bus.done), 32'd0);
    do_scan(3'd3, 2'd0, 5, 4, 1'b0, "t_free", -1);
    board[5] = 10'd0;

    @(negedge clk); do_scan(3'd2, 2'd0, -2, 0, 1'b1, "glitch_start", 2);
    @(negedge clk); do_scan(3'd2, 2'd0, -2, 0, 1'b1, "b2b_first", -1);
    do_scan(3'd1, 2'd0, 0, 0, 1'b0, "b2b_second", -1);

    // reset in the middle of a scan
    @(negedge clk);
    bus.start = 1'b1; bus.tetro_in = 3'd2; bus.dir_in = 2'd0; bus.pos_x = 5'(-2); bus.pos_y = 6'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_hit", 32'(bus.hit), 32'd0);
    chk("midrst_addr", 32'(bus.board_row_addr), 32'd0);
    chk("midrst_tetro", 32'(bus.rom_tetro), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    chk("midrst_no_done", 32'(done_seen), 32'd0);
    do_scan(3'd2, 2'd1, 7, 0, 1'b1, "after_reset", -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
